// File: rtl/mult_share_pkg.sv
// -----------------------------------------------------------------------------
// mult_share_pkg
//   Shared constants, pipeline-stage payload types and the 3:2 carry-save
//   compressor used by the multiplier reduction tree.
// -----------------------------------------------------------------------------
package mult_share_pkg;

    localparam int MULT_W   = 8;   // operand width
    localparam int PROD_W   = 16;  // unsigned product width
    localparam int MAX_ID_W = 3;   // widest requester index (up to 8 requesters)

    // Stage 1 payload: operands feeding the multiplier plus the issuing requester.
    typedef struct packed {
        logic [MULT_W-1:0]   a;
        logic [MULT_W-1:0]   b;
        logic [MAX_ID_W-1:0] id;
    } s1_t;

    // Stage 2 payload: the registered product plus the issuing requester.
    typedef struct packed {
        logic [PROD_W-1:0]   prod;
        logic [MAX_ID_W-1:0] id;
    } s2_t;

    // Redundant (sum, carry) pair produced by one compressor row.
    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
    } csa_t;

    // Full-adder row: x + y + z == sum + carry.
    // The carry shifted out of bit 15 is always 0 here, because every partial
    // sum in the tree stays below 2**16.
    function automatic csa_t csa3(input logic [PROD_W-1:0] x,
                                  input logic [PROD_W-1:0] y,
                                  input logic [PROD_W-1:0] z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// -----------------------------------------------------------------------------
// mult_module
//   Combinational 8x8 unsigned Dadda multiplier. Eight partial-product rows are
//   reduced 8 -> 6 -> 4 -> 3 -> 2 with carry-save rows, then one adder resolves
//   the final pair.
// Ports
//   a, b          in   8   operands
//   result_a      out  16  final sum row of the reduction tree
//   result_b      out  16  final carry row of the reduction tree
//   result_final  out  17  result_a + result_b (bit 16 is always 0 for 8x8)
// -----------------------------------------------------------------------------
module mult_module
    import mult_share_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    output logic [PROD_W-1:0] result_a,
    output logic [PROD_W-1:0] result_b,
    output logic [PROD_W:0]   result_final
);

    logic [PROD_W-1:0] w_pp [MULT_W];
    csa_t w_l1_0, w_l1_1, w_l2_0, w_l2_1, w_l3, w_l4;

    always_comb begin
        for (int i = 0; i < MULT_W; i++) begin
            w_pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
        end
    end

    // Row height 8 -> 6
    assign w_l1_0 = csa3(w_pp[0], w_pp[1], w_pp[2]);
    assign w_l1_1 = csa3(w_pp[3], w_pp[4], w_pp[5]);
    // Row height 6 -> 4
    assign w_l2_0 = csa3(w_l1_0.sum, w_l1_0.carry, w_l1_1.sum);
    assign w_l2_1 = csa3(w_l1_1.carry, w_pp[6], w_pp[7]);
    // Row height 4 -> 3
    assign w_l3   = csa3(w_l2_0.sum, w_l2_0.carry, w_l2_1.sum);
    // Row height 3 -> 2
    assign w_l4   = csa3(w_l3.sum, w_l3.carry, w_l2_1.carry);

    assign result_a     = w_l4.sum;
    assign result_b     = w_l4.carry;
    assign result_final = {1'b0, result_a} + {1'b0, result_b};

endmodule

// File: rtl/mult_share_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker: grants the first requester at or
//   after ptr whose req and en bits are both set. The pointer lives in the
//   caller.
// Ports
//   req         in   NUM_REQ  request bits
//   en          in   NUM_REQ  enable mask
//   ptr         in   ID_W     highest-priority index this cycle
//   gnt_onehot  out  NUM_REQ  one-hot grant (all zero if nothing eligible)
//   gnt_idx     out  ID_W     index of the granted requester
//   any_gnt     out  1        a grant was found
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_gnt
);

    int w_idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path
        // leaves a value unassigned, which would infer a latch.
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_gnt && req[w_idx] && en[w_idx]) begin
                any_gnt           = 1'b1;
                gnt_idx           = ID_W'(w_idx);
                gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one combinational 8x8 multiplier among NUM_REQ requesters through a
//   two-stage pipeline (S1: operands, S2: product) with round-robin admission
//   of one operand pair per cycle and a valid/ready response port.
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   cfg_en     in   NUM_REQ    per-requester arbitration enable
//   req_valid  in   NUM_REQ    request valid per requester
//   req_ready  out  NUM_REQ    one-hot grant; handshake on valid & ready
//   req_a      in   8*NUM_REQ  operand A, slice i for requester i
//   req_b      in   8*NUM_REQ  operand B, slice i for requester i
//   rsp_valid  out  1          product valid
//   rsp_ready  in   1          consumer accepts the product
//   rsp_id     out  ID_W       issuing requester of the product
//   rsp_data   out  16         unsigned product
//   busy       out  1          S1 or S2 holds a valid entry
// -----------------------------------------------------------------------------
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        cfg_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [MULT_W*NUM_REQ-1:0] req_a,
    input  logic [MULT_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_data,
    output logic                      busy
);

    logic              r_s1_v;
    logic              r_s2_v;
    s1_t               r_s1;
    s2_t               r_s2;
    logic [ID_W-1:0]   r_ptr;

    logic              w_adv1;
    logic              w_adv2;
    logic              w_hs;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_any_gnt;
    logic [ID_W-1:0]   w_ptr_next;
    logic [PROD_W:0]   w_prod_full;

    // A stage may accept new data when it is empty or its content moves on.
    assign w_adv2 = !r_s2_v || rsp_ready;
    assign w_adv1 = !r_s1_v || w_adv2;

    // Grant depends only on valid/enable/pointer, never on operand values.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .en         (cfg_en),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any_gnt    (w_any_gnt)
    );

    assign req_ready  = (w_adv1 && !rst) ? w_gnt_onehot : '0;
    assign w_hs       = w_adv1 && w_any_gnt;
    assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    mult_module u_mult (
        .a            (r_s1.a),
        .b            (r_s1.b),
        .result_a     (),
        .result_b     (),
        .result_final (w_prod_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload registers are cleared as well as the valid
            // bits, since rsp_id/rsp_data are observable and must read 0
            // straight out of reset.
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s1   <= '0;
            r_s2   <= '0;
            r_ptr  <= '0;
        end else begin
            // NOTE: non-blocking assignments let S2 capture the S1 contents
            // from before this edge while S1 is reloaded in the same edge.
            if (w_hs) begin
                r_s1_v <= 1'b1;
                r_s1.a <= req_a[MULT_W*int'(w_gnt_idx) +: MULT_W];
                r_s1.b <= req_b[MULT_W*int'(w_gnt_idx) +: MULT_W];
                r_s1.id <= MAX_ID_W'(w_gnt_idx);
                r_ptr  <= w_ptr_next;
            end else if (w_adv1) begin
                r_s1_v <= 1'b0;
            end

            if (w_adv2) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    // Bit 16 of the sum is dropped: 255*255 fits in 16 bits.
                    r_s2.prod <= w_prod_full[PROD_W-1:0];
                    r_s2.id   <= r_s1.id;
                end
            end
        end
    end

    assign rsp_valid = r_s2_v;
    assign rsp_data  = r_s2.prod;
    assign rsp_id    = r_s2.id[ID_W-1:0];
    assign busy      = r_s1_v || r_s2_v;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Scoreboard bench. A reference model predicts each grant from a round-robin
//   pointer and the number of products still owed to the consumer, and queues
//   the expected (id, a*b) for every accepted request. A separate monitor pops
//   and compares whenever a response is accepted.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cfg_en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [8*N-1:0] req_a;
    logic [8*N-1:0] req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [15:0]   rsp_data;
    logic          busy;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int prod;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_ptr    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [31:0] av, bv;
        av = a;
        bv = b;
        req_a[i*8 +: 8] = av[7:0];
        req_b[i*8 +: 8] = bv[7:0];
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // ---------------- reference model: grant prediction + expected queue ----
    exp_t       b_pend;
    bit         b_have;
    bit         b_allowed;
    int         b_g;
    logic [N-1:0] b_exp;

    always begin
        @(negedge clk);
        b_have = 1'b0;
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end else begin
            // New work can enter unless two products are already owed and the
            // consumer is not taking one this cycle.
            b_allowed = (sb.size() < 2) || rsp_ready;
            b_g   = -1;
            b_exp = '0;
            if (b_allowed) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (b_g < 0 && req_valid[idx] && cfg_en[idx]) b_g = idx;
                end
            end
            if (b_g >= 0) b_exp[b_g] = 1'b1;
            check("grant", 32'(req_ready), 32'(b_exp));
            if (b_g >= 0) begin
                b_pend.id   = b_g;
                b_pend.prod = int'(req_a[b_g*8 +: 8]) * int'(req_b[b_g*8 +: 8]);
                b_have      = 1'b1;
                m_ptr       = (b_g + 1) % N;
            end
            if (dut.r_s1_v) check("prod_bit16", 32'(dut.w_prod_full[16]), 32'd0);
        end
        @(posedge clk);
        if (b_have) sb.push_back(b_pend);
    end

    // ---------------- monitor ------------------------------------------------
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_without_request", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.prod));
            end
        end
    end

    // ---------------- watchdog -----------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    // ---------------- stimulus -----------------------------------------------
    initial begin
        rst       = 1'b1;
        cfg_en    = '1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        step();
        step();
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        step();

        // 1. single op, two-cycle latency
        rsp_ready = 1'b1;
        set_op(0, 3, 5);
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check("t1_valid_n1", 32'(rsp_valid), 32'd0);
        check("t1_busy_n1", 32'(busy), 32'd1);
        step();
        check("t1_valid_n2", 32'(rsp_valid), 32'd1);
        check("t1_data", 32'(rsp_data), 32'd15);
        check("t1_id", 32'(rsp_id), 32'd0);
        step();
        check("t1_valid_after", 32'(rsp_valid), 32'd0);

        // 2. corner operands on requester 2
        for (int k = 0; k < 3; k++) begin
            int ca [3];
            int cb [3];
            ca = '{255, 0, 128};
            cb = '{255, 200, 2};
            set_op(2, ca[k], cb[k]);
            req_valid = 4'b0100;
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // 3. all requesters continuously valid
        do_reset();
        cfg_en    = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t3_grant_order", 32'(req_ready), 32'(1 << (k % N)));
            step();
            for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
            if (k >= 1) begin
                check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
                check("t3_rsp_id", 32'(rsp_id), 32'((k - 1) % N));
            end
        end
        req_valid = '0;
        repeat (3) step();

        // 4. backpressure with both stages full
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 10 + i, 20 + i);
        req_valid = '1;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_id", 32'(rsp_id), 32'd0);
            check("t4_hold_data", 32'(rsp_data), 32'd200);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("t4_release_first", 32'(rsp_valid), 32'd1);
        step();
        check("t4_release_second", 32'(rsp_valid), 32'd1);
        check("t4_second_id", 32'(rsp_id), 32'd1);
        check("t4_second_data", 32'(rsp_data), 32'd231);
        step();
        check("t4_drained", 32'(rsp_valid), 32'd0);

        // 5. masking: only requesters 1 and 3 eligible
        do_reset();
        cfg_en    = 4'b1010;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t5_mask_grant", 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            step();
        end
        req_valid = '0;
        cfg_en    = '1;
        repeat (3) step();

        // 6. reset while both stages are full
        rsp_ready = 1'b0;
        req_valid = '1;
        step();
        step();
        check("t6_full_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("t6_rst_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_no_stale", 32'(rsp_valid), 32'd0);
        end
        req_valid = '1;
        #1;
        check("t6_ptr_zero", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (3) step();

        // 7. randomized traffic
        for (int k = 0; k < 3000; k++) begin
            req_valid = N'($urandom);
            if ($urandom_range(0, 15) == 0) cfg_en = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                set_op($urandom_range(0, N - 1), 255, 255);
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        step();
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
